// File: rtl/run_pkg.sv
// Shared types and constants for the run-control / self-check block.
package run_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    RUN      = 3'd2,
    CHK_ADDR = 3'd3,
    CHK_CMP  = 3'd4,
    DONE     = 3'd5
  } run_state_t;

  // jal x0,0 : the core spins on itself at end of program
  localparam logic [31:0] HALT_JAL_SELF = 32'h0000006F;

  // Width of fail_index: enough for every check index plus an all-ones "none" code
  function automatic int unsigned fi_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/run_control_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_control.sv
// Run-control for the multicycle core: holds it in reset, runs it to the halt
// idiom or a timeout, then reads back registers and produces a pass/fail verdict.
module run_control
  import run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 4096,
  parameter int unsigned NUM_CHECKS   = 4,
  parameter int unsigned DATA_W       = 64,
  parameter logic [31:0] HALT_INSTR   = HALT_JAL_SELF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [31:0]                         instr,
  input  logic                                instr_valid,
  input  logic [NUM_CHECKS*5-1:0]             chk_addr_flat,
  input  logic [NUM_CHECKS*DATA_W-1:0]        chk_data_flat,
  output logic [4:0]                          dbg_addr,
  input  logic [DATA_W-1:0]                   dbg_data,
  output logic                                cpu_reset,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic                                timeout,
  output logic [fi_width(NUM_CHECKS)-1:0]     fail_index,
  output logic [CNT_W-1:0]                    cycle_count,
  output logic [CNT_W-1:0]                    instr_count
);

  localparam int unsigned    FI_W     = fi_width(NUM_CHECKS);
  localparam int unsigned    HOLD_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [FI_W-1:0] LAST_IDX = FI_W'(NUM_CHECKS - 1);

  run_state_t          state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [FI_W-1:0]     idx, idx_nxt;
  logic [FI_W-1:0]     fail_index_nxt;
  logic                pass_nxt, timeout_nxt;
  logic                cnt_clr, cyc_en, ins_en;
  logic [DATA_W-1:0]   exp_data;
  logic [4:0]          addr_sel;

  // Expected value for the check currently being compared
  always_comb begin
    exp_data = '0;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      if (idx == FI_W'(k)) exp_data = chk_data_flat[k*DATA_W +: DATA_W];
    end
  end

  // Register index for the check about to be addressed
  always_comb begin
    addr_sel = '0;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      if (idx_nxt == FI_W'(k)) addr_sel = chk_addr_flat[k*5 +: 5];
    end
  end

  // Next-state and next-result logic
  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    idx_nxt        = idx;
    pass_nxt       = pass;
    timeout_nxt    = timeout;
    fail_index_nxt = fail_index;
    cnt_clr        = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = HOLD;
          hold_cnt_nxt   = '0;
          cnt_clr        = 1'b1;
          pass_nxt       = 1'b0;
          timeout_nxt    = 1'b0;
          fail_index_nxt = '1;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) state_nxt = RUN;
        else                                       hold_cnt_nxt = hold_cnt + HOLD_W'(1);
      end
      RUN: begin
        // Halt has priority over a timeout landing on the same cycle
        if (instr_valid && (instr == HALT_INSTR)) begin
          state_nxt = CHK_ADDR;
          idx_nxt   = '0;
        end else if (cycle_count == CNT_W'(TIMEOUT - 1)) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
          pass_nxt    = 1'b0;
        end
      end
      CHK_ADDR: state_nxt = CHK_CMP;
      CHK_CMP: begin
        if (dbg_data != exp_data) begin
          fail_index_nxt = idx;
          pass_nxt       = 1'b0;
          state_nxt      = DONE;
        end else if (idx == LAST_IDX) begin
          pass_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + FI_W'(1);
          state_nxt = CHK_ADDR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cyc_en = (state == RUN);
  assign ins_en = (state == RUN) && instr_valid;

  // State and registered outputs; status flags follow the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      idx        <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      fail_index <= '1;
      dbg_addr   <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      idx        <= idx_nxt;
      cpu_reset  <= (state_nxt != RUN);
      busy       <= (state_nxt != IDLE) && (state_nxt != DONE);
      done       <= (state_nxt == DONE);
      pass       <= pass_nxt;
      timeout    <= timeout_nxt;
      fail_index <= fail_index_nxt;
      if (state_nxt == CHK_ADDR) dbg_addr <= addr_sel;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cyc_en),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (ins_en),
    .q     (instr_count)
  );

endmodule
